// File: rtl/ahb_pkg.sv
// AHB protocol constants and slave FSM encodings, shared by the
// AHB slave and the AXI-to-AHB bridge.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } ahb_state_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe and alignment check for a 32-bit AHB data bus,
// little-endian lane numbering.
module ahb_strb_gen
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    output logic [3:0] strb,
    output logic       misalign
);

    always_comb begin
        strb     = 4'h0;
        misalign = 1'b0;
        unique case (1'b1)
            (hsize == HSIZE_BYTE): begin
                strb = 4'b0001 << addr;
            end
            (hsize == HSIZE_HALF): begin
                strb     = 4'b0011 << addr;
                misalign = addr[0];
            end
            (hsize == HSIZE_WORD): begin
                strb     = 4'hF;
                misalign = (addr != 2'b00);
            end
            default: begin
                strb     = 4'h0;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave fronting a word-addressed on-chip SRAM, with optional
// wait states and two-cycle ERROR responses for illegal transfers.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned W_ADDR      = 32,
    parameter int unsigned W_DATA      = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter logic [W_ADDR-1:0] BASE_ADDR = '0,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ahb_hsel,
    input  logic [W_ADDR-1:0] ahb_haddr,
    input  logic [1:0]        ahb_htrans,
    input  logic              ahb_hwrite,
    input  logic [2:0]        ahb_hsize,
    input  logic [2:0]        ahb_hburst,
    input  logic [W_DATA-1:0] ahb_hwdata,
    input  logic              ahb_hready_in,
    output logic              ahb_hreadyout,
    output logic [1:0]        ahb_hresp,
    output logic [W_DATA-1:0] ahb_hrdata
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [W_ADDR:0] LIMIT = (W_ADDR+1)'(4 * MEM_DEPTH);
    localparam logic [2:0] WS3 = 3'(WAIT_STATES);

    logic [W_DATA-1:0] mem [MEM_DEPTH];

    ahb_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              dp_vld_q, dp_vld_d;
    logic              dp_wr_q, dp_wr_d;
    logic [AW-1:0]     dp_idx_q, dp_idx_d;
    logic [3:0]        dp_strb_q, dp_strb_d;
    logic [W_DATA-1:0] rdata_q, rdata_d;

    logic [W_ADDR:0]   off;
    logic [AW-1:0]     acc_idx;
    logic [3:0]        acc_strb;
    logic              acc_mis;
    logic              acc_err;
    logic              accept;
    logic              hready;
    logic              wr_en;
    logic [W_DATA-1:0] rd_word;
    logic [W_DATA-1:0] rd_fwd;
    logic [W_DATA-1:0] wr_word;
    logic              unused_hburst;

    assign unused_hburst = ^ahb_hburst;

    ahb_strb_gen u_strb (
        .hsize    (ahb_hsize),
        .addr     (ahb_haddr[1:0]),
        .strb     (acc_strb),
        .misalign (acc_mis)
    );

    // An address below BASE_ADDR wraps negative and sets the top bit.
    assign off     = {1'b0, ahb_haddr} - {1'b0, BASE_ADDR};
    assign acc_idx = off[AW+1:2];
    assign acc_err = (ahb_hsize > HSIZE_WORD) | acc_mis
                   | off[W_ADDR] | (off >= LIMIT);

    assign hready = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign accept = ahb_hsel & ahb_hready_in & ahb_htrans[1] & hready;

    assign wr_en   = rst_n & hready & dp_vld_q & dp_wr_q;
    assign wr_word = byte_merge(mem[dp_idx_q], ahb_hwdata, dp_strb_q);
    assign rd_word = mem[acc_idx];
    assign rd_fwd  = (wr_en && dp_idx_q == acc_idx)
                   ? byte_merge(rd_word, ahb_hwdata, dp_strb_q)
                   : rd_word;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dp_vld_d  = dp_vld_q;
        dp_wr_d   = dp_wr_q;
        dp_idx_d  = dp_idx_q;
        dp_strb_d = dp_strb_q;
        rdata_d   = rdata_q;
        if (hready) begin
            state_d  = S_IDLE;
            dp_vld_d = 1'b0;
            rdata_d  = '0;
            if (accept) begin
                dp_wr_d   = ahb_hwrite;
                dp_idx_d  = acc_idx;
                dp_strb_d = acc_strb;
                if (acc_err) begin
                    state_d = S_ERR1;
                end else begin
                    dp_vld_d = 1'b1;
                    rdata_d  = ahb_hwrite ? '0 : rd_fwd;
                    if (WAIT_STATES != 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS3;
                    end
                end
            end
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = S_IDLE;
                end
                S_ERR1: state_d = S_ERR2;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dp_vld_q  <= 1'b0;
            dp_wr_q   <= 1'b0;
            dp_idx_q  <= '0;
            dp_strb_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dp_vld_q  <= dp_vld_d;
            dp_wr_q   <= dp_wr_d;
            dp_idx_q  <= dp_idx_d;
            dp_strb_q <= dp_strb_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[dp_idx_q] <= wr_word;
    end

    assign ahb_hreadyout = hready;
    assign ahb_hresp = ((state_q == S_ERR1) || (state_q == S_ERR2))
                     ? HRESP_ERROR : HRESP_OKAY;
    assign ahb_hrdata = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one zero-wait slave and one two-wait-state slave
// sharing the master-side address/control signals.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel0, hsel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        rdy0, rdy2;
    logic [1:0]  resp0, resp2;
    logic [31:0] rd0, rd2;

    int checks = 0;
    int errors = 0;
    logic [31:0] d;

    always #5 clk = ~clk;

    ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ahb_hsel(hsel0), .ahb_haddr(haddr),
        .ahb_htrans(htrans), .ahb_hwrite(hwrite), .ahb_hsize(hsize),
        .ahb_hburst(hburst), .ahb_hwdata(hwdata), .ahb_hready_in(rdy0),
        .ahb_hreadyout(rdy0), .ahb_hresp(resp0), .ahb_hrdata(rd0)
    );

    ahb_sram_slave #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ahb_hsel(hsel2), .ahb_haddr(haddr),
        .ahb_htrans(htrans), .ahb_hwrite(hwrite), .ahb_hsize(hsize),
        .ahb_hburst(hburst), .ahb_hwdata(hwdata), .ahb_hready_in(rdy2),
        .ahb_hreadyout(rdy2), .ahb_hresp(resp2), .ahb_hrdata(rd2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic addr_ph(input logic s2, input logic [31:0] a,
                           input logic w, input logic [2:0] sz,
                           input logic [1:0] tr);
        hsel0  = ~s2;
        hsel2  = s2;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = tr;
    endtask

    task automatic bus_idle();
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] dat,
                       input logic [2:0] sz);
        addr_ph(1'b0, a, 1'b1, sz, HTRANS_NONSEQ);
        cyc();
        bus_idle();
        hwdata = dat;
        chk("wr_rdy", 32'(rdy0), 32'd1);
        cyc();
    endtask

    task automatic rdw0(input logic [31:0] a, output logic [31:0] dat);
        addr_ph(1'b0, a, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        cyc();
        bus_idle();
        chk("rd_rdy", 32'(rdy0), 32'd1);
        chk("rd_resp", 32'(resp0), 32'(HRESP_OKAY));
        dat = rd0;
        cyc();
    endtask

    initial begin
        rst_n  = 1'b0;
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        haddr  = '0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        hburst = HBURST_SINGLE;
        hwdata = '0;
        repeat (3) cyc();
        chk("rst_rdy0", 32'(rdy0), 32'd1);
        chk("rst_resp0", 32'(resp0), 32'(HRESP_OKAY));
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rdy2", 32'(rdy2), 32'd1);
        rst_n = 1'b1;
        cyc();

        // word write then read, zero wait
        wr0(32'h34, 32'hDEADBEEF, HSIZE_WORD);
        rdw0(32'h34, d);
        chk("t1_rd", d, 32'hDEADBEEF);

        // INCR4 write then INCR4 read, back-to-back
        hburst = HBURST_INCR4;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4)
                addr_ph(1'b0, 32'h40 + 32'(4*i), 1'b1, HSIZE_WORD,
                        (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
            else
                bus_idle();
            if (i > 0) begin
                hwdata = 32'(i);
                chk("t2_wr_rdy", 32'(rdy0), 32'd1);
            end
            cyc();
        end
        for (int i = 0; i <= 4; i++) begin
            if (i < 4)
                addr_ph(1'b0, 32'h40 + 32'(4*i), 1'b0, HSIZE_WORD,
                        (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
            else
                bus_idle();
            if (i > 0) begin
                chk("t2_rd_rdy", 32'(rdy0), 32'd1);
                chk("t2_rd", rd0, 32'(i));
            end
            cyc();
        end
        hburst = HBURST_SINGLE;

        // two wait states on the second slave
        addr_ph(1'b1, 32'h34, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        cyc();
        bus_idle();
        hwdata = 32'hDEADBEEF;
        chk("t3_wr_w1", 32'(rdy2), 32'd0);
        cyc();
        chk("t3_wr_w2", 32'(rdy2), 32'd0);
        cyc();
        chk("t3_wr_done", 32'(rdy2), 32'd1);
        cyc();
        addr_ph(1'b1, 32'h34, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        cyc();
        bus_idle();
        chk("t3_rd_w1", 32'(rdy2), 32'd0);
        chk("t3_rd_w1_resp", 32'(resp2), 32'(HRESP_OKAY));
        cyc();
        chk("t3_rd_w2", 32'(rdy2), 32'd0);
        chk("t3_rd_hold", rd2, 32'hDEADBEEF);
        cyc();
        chk("t3_rd_rdy", 32'(rdy2), 32'd1);
        chk("t3_rd", rd2, 32'hDEADBEEF);
        cyc();

        // byte write into a word
        wr0(32'h34, 32'h11223344, HSIZE_WORD);
        wr0(32'h35, 32'h0000AB00, HSIZE_BYTE);
        rdw0(32'h34, d);
        chk("t4_byte", d, 32'h1122AB44);

        // out-of-range write (index would alias word 0)
        wr0(32'h0, 32'h01020304, HSIZE_WORD);
        addr_ph(1'b0, 32'h1000, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        cyc();
        bus_idle();
        hwdata = 32'hFFFFFFFF;
        chk("t5a_e1_rdy", 32'(rdy0), 32'd0);
        chk("t5a_e1_resp", 32'(resp0), 32'(HRESP_ERROR));
        cyc();
        chk("t5a_e2_rdy", 32'(rdy0), 32'd1);
        chk("t5a_e2_resp", 32'(resp0), 32'(HRESP_ERROR));
        cyc();
        chk("t5a_okay", 32'(resp0), 32'(HRESP_OKAY));
        rdw0(32'h0, d);
        chk("t5a_word0", d, 32'h01020304);

        // misaligned word write
        addr_ph(1'b0, 32'h36, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        cyc();
        bus_idle();
        hwdata = 32'hFFFFFFFF;
        chk("t5b_e1_rdy", 32'(rdy0), 32'd0);
        chk("t5b_e1_resp", 32'(resp0), 32'(HRESP_ERROR));
        cyc();
        chk("t5b_e2_rdy", 32'(rdy0), 32'd1);
        chk("t5b_e2_resp", 32'(resp0), 32'(HRESP_ERROR));
        cyc();
        chk("t5b_okay", 32'(resp0), 32'(HRESP_OKAY));
        rdw0(32'h34, d);
        chk("t5b_word34", d, 32'h1122AB44);

        // write immediately followed by read of the same word
        addr_ph(1'b0, 32'h50, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        cyc();
        hwdata = 32'hCAFE0001;
        addr_ph(1'b0, 32'h50, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        cyc();
        bus_idle();
        chk("t6_fwd_rdy", 32'(rdy0), 32'd1);
        chk("t6_fwd", rd0, 32'hCAFE0001);
        cyc();

        // reset in the middle of an INCR4 write
        for (int i = 0; i < 4; i++)
            wr0(32'h60 + 32'(4*i), 32'hA0 + 32'(i), HSIZE_WORD);
        hburst = HBURST_INCR4;
        addr_ph(1'b0, 32'h60, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        cyc();
        addr_ph(1'b0, 32'h64, 1'b1, HSIZE_WORD, HTRANS_SEQ);
        hwdata = 32'h11;
        cyc();
        addr_ph(1'b0, 32'h68, 1'b1, HSIZE_WORD, HTRANS_SEQ);
        hwdata = 32'h22;
        cyc();
        addr_ph(1'b0, 32'h6C, 1'b1, HSIZE_WORD, HTRANS_SEQ);
        hwdata = 32'h33;
        rst_n = 1'b0;
        cyc();
        chk("t6_rst_rdy", 32'(rdy0), 32'd1);
        chk("t6_rst_resp", 32'(resp0), 32'(HRESP_OKAY));
        chk("t6_rst_rd", rd0, 32'h0);
        rst_n = 1'b1;
        bus_idle();
        hburst = HBURST_SINGLE;
        hwdata = 32'h44;
        cyc();
        rdw0(32'h60, d);
        chk("t6_b1", d, 32'h11);
        rdw0(32'h64, d);
        chk("t6_b2", d, 32'h22);
        rdw0(32'h68, d);
        chk("t6_b3", d, 32'hA2);
        rdw0(32'h6C, d);
        chk("t6_b4", d, 32'hA3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
